// File: rtl/video_pkg.sv
// Shared constants for the raster timing / test-pattern generator:
// BT.709 75 % bar table, blanking and TRS words, fvht bit positions.
package video_pkg;

  typedef struct packed {
    logic [9:0] y;
    logic [9:0] cb;
    logic [9:0] cr;
  } ycbcr_t;

  // White, yellow, cyan, green, magenta, red, blue, black.
  localparam ycbcr_t BAR_TABLE [8] = '{
    '{y: 10'd721, cb: 10'd512, cr: 10'd512},
    '{y: 10'd674, cb: 10'd176, cr: 10'd543},
    '{y: 10'd581, cb: 10'd589, cr: 10'd176},
    '{y: 10'd534, cb: 10'd253, cr: 10'd207},
    '{y: 10'd251, cb: 10'd771, cr: 10'd817},
    '{y: 10'd204, cb: 10'd435, cr: 10'd848},
    '{y: 10'd111, cb: 10'd848, cr: 10'd481},
    '{y: 10'd64,  cb: 10'd512, cr: 10'd512}
  };

  localparam logic [9:0] BLANK_Y   = 10'd64;
  localparam logic [9:0] BLANK_C   = 10'd512;
  localparam logic [9:0] TRS_ONES  = 10'h3FF;
  localparam logic [9:0] TRS_ZEROS = 10'h000;

  localparam int FVHT_F = 3;
  localparam int FVHT_V = 2;
  localparam int FVHT_H = 1;
  localparam int FVHT_T = 0;

  function automatic logic [9:0] trs_xyz(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Horizontal/vertical raster counters and fvht flag decode. Starts at EAV of
// the last line so the first frame begins cleanly after reset.
module raster_counter
  import video_pkg::*;
#(
  parameter int H_TOTAL  = 2200,
  parameter int H_ACTIVE = 1920,
  parameter int V_TOTAL  = 1125,
  parameter int V_BLANK  = 45
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cen_i,
  output logic [$clog2(H_TOTAL)-1:0] h_cnt_o,
  output logic [3:0]                 fvht_o,
  output logic                       eav_o,
  output logic [1:0]                 trs_idx_o,
  output logic                       line_end_o,
  output logic                       frame_latch_o
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_EAV     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EAV_END = HW'(H_ACTIVE + 4);
  localparam logic [HW-1:0] H_SAV     = HW'(H_TOTAL - 4);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_BLK     = VW'(V_BLANK);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          v_flag_q, v_flag_d;
  logic          h_wrap, in_eav, in_sav;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
    // v is only re-evaluated at EAV so its rise always coincides with an h rise.
    v_flag_d = (h_cnt_q == H_EAV) ? (v_cnt_q < V_BLK) : v_flag_q;
    in_eav   = (h_cnt_q >= H_EAV) && (h_cnt_q < H_EAV_END);
    in_sav   = (h_cnt_q >= H_SAV);

    fvht_o         = '0;
    fvht_o[FVHT_F] = 1'b0;
    fvht_o[FVHT_V] = v_flag_d;
    fvht_o[FVHT_H] = (h_cnt_q >= H_EAV);
    fvht_o[FVHT_T] = in_eav || in_sav;

    eav_o         = in_eav;
    trs_idx_o     = in_sav ? 2'(h_cnt_q - H_SAV) : 2'(h_cnt_q - H_EAV);
    line_end_o    = h_wrap;
    frame_latch_o = (h_cnt_q == H_EAV) && (v_cnt_q == V_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q  <= H_EAV;
      v_cnt_q  <= V_LAST;
      v_flag_q <= 1'b0;
    end else if (cen_i) begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      v_flag_q <= v_flag_d;
    end
  end

  assign h_cnt_o = h_cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// 1080p-style raster source: fvht timing plus colour-bar/ramp and flat-colour
// 4:2:2 10-bit multiplexed streams, all registered and advancing on cen_i.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_TOTAL  = 2200,
  parameter int H_ACTIVE = 1920,
  parameter int V_TOTAL  = 1125,
  parameter int V_BLANK  = 45
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic        pattern_sel_i,
  input  logic [29:0] colour_i,
  output logic [3:0]  fvht_o,
  output logic [19:0] vdat_bars_o,
  output logic [19:0] vdat_colour_o
);

  localparam int HW    = $clog2(H_TOTAL);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [HW-1:0] h_cnt;
  logic [3:0]    fvht;
  logic          eav, line_end, frame_latch;
  logic [1:0]    trs_idx;

  raster_counter #(
    .H_TOTAL (H_TOTAL),
    .H_ACTIVE(H_ACTIVE),
    .V_TOTAL (V_TOTAL),
    .V_BLANK (V_BLANK)
  ) u_raster (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cen_i        (cen_i),
    .h_cnt_o      (h_cnt),
    .fvht_o       (fvht),
    .eav_o        (eav),
    .trs_idx_o    (trs_idx),
    .line_end_o   (line_end),
    .frame_latch_o(frame_latch)
  );

  logic [BW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic          sel_q, sel_d;
  ycbcr_t        col_q, col_d;
  logic [3:0]    fvht_q;
  logic [19:0]   bars_q, bars_d;
  logic [19:0]   colour_q, colour_d;

  logic [9:0]    trs_word;
  ycbcr_t        bar;
  logic          odd;

  // Bar position tracked by a width down-counter and an index, avoiding a divider.
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (line_end) begin
      bar_cnt_d = BAR_LAST;
      bar_idx_d = '0;
    end else if (!fvht[FVHT_H]) begin
      if (bar_cnt_q == '0) begin
        bar_cnt_d = BAR_LAST;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q - BW'(1);
      end
    end

    sel_d = frame_latch ? pattern_sel_i : sel_q;
    col_d = frame_latch ? ycbcr_t'(colour_i) : col_q;
  end

  always_comb begin
    case (trs_idx)
      2'd0:    trs_word = TRS_ONES;
      2'd1,
      2'd2:    trs_word = TRS_ZEROS;
      default: trs_word = trs_xyz(fvht[FVHT_F], fvht[FVHT_V], eav);
    endcase

    bar      = BAR_TABLE[bar_idx_q];
    odd      = h_cnt[0];
    bars_d   = {BLANK_Y, BLANK_C};
    colour_d = {BLANK_Y, BLANK_C};

    if (fvht[FVHT_T]) begin
      bars_d   = {trs_word, trs_word};
      colour_d = {trs_word, trs_word};
    end else if (!fvht[FVHT_H] && !fvht[FVHT_V]) begin
      if (sel_q) begin
        bars_d = {BLANK_Y + 10'(9'(h_cnt >> 2)), BLANK_C};
      end else begin
        bars_d = {bar.y, odd ? bar.cr : bar.cb};
      end
      colour_d = {col_q.y, odd ? col_q.cr : col_q.cb};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bar_cnt_q <= BAR_LAST;
      bar_idx_q <= '0;
      sel_q     <= 1'b0;
      col_q     <= '{y: BLANK_Y, cb: BLANK_C, cr: BLANK_C};
      fvht_q    <= '0;
      bars_q    <= '0;
      colour_q  <= '0;
    end else if (cen_i) begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      sel_q     <= sel_d;
      col_q     <= col_d;
      fvht_q    <= fvht;
      bars_q    <= bars_d;
      colour_q  <= colour_d;
    end
  end

  assign fvht_o        = fvht_q;
  assign vdat_bars_o   = bars_q;
  assign vdat_colour_o = colour_q;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Upstream source for the square-overlay stage. Generates 1080p-style raster timing (`fvht`) and two 4:2:2 10-bit multiplexed video streams: a colour-bar or luma-ramp test pattern, and a flat programmable colour. All logic advances only on `cen_i`. Outputs connect directly to the overlay stage's `fvht_i`, `vdat_bars_i` and `vdat_colour_i`.

## Interface

**Parameters**
- `H_TOTAL`, default 2200: clocks per line.
- `H_ACTIVE`, default 1920: active pixels per line. Must be even and divisible by 8.
- `V_TOTAL`, default 1125: lines per frame.
- `V_BLANK`, default 45: blanking lines at the start of each frame.

**Ports** (clock and reset first)
- `clk_i`, in, 1: clock. The block uses this one clock only.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `cen_i`, in, 1: clock enable.
- `pattern_sel_i`, in, 1: 0 = colour bars, 1 = luma ramp.
- `colour_i`, in, 30: flat colour `{Y, Cb, Cr}`, 10 bits each.
- `fvht_o`, out, 4: `{f, v, h, t}`.
- `vdat_bars_o`, out, 20: pattern video `{Y, C}`.
- `vdat_colour_o`, out, 20: flat-colour video `{Y, C}`.

## Operation

**Counters**
- `h_cnt` runs 0..`H_TOTAL`-1.
- `v_cnt` runs 0..`V_TOTAL`-1 and increments when `h_cnt` wraps.
- Reset values: `h_cnt` = `H_ACTIVE`, `v_cnt` = `V_TOTAL`-1, so the block starts at EAV of the last line.

**Timing flags** (decoded from the counters)
- `h` = 1 when `h_cnt >= H_ACTIVE`. This spans EAV, ancillary and SAV.
- `v` = 1 when `v_cnt < V_BLANK`. `v` only changes while `h_cnt == H_ACTIVE`, so a `v` rise always coincides with an `h` rise.
- `f` = 0 always (progressive).
- `t` = 1 on the four EAV words (`h_cnt` = `H_ACTIVE`..`H_ACTIVE`+3) and the four SAV words (`h_cnt` = `H_TOTAL`-4..`H_TOTAL`-1).

**TRS words**
- The same word is driven on both Y and C for both outputs: `3FF`, `000`, `000`, `XYZ`.
- `XYZ` = `{1, F, V, H, P3, P2, P1, P0, 0, 0}`, with P3 = V^H, P2 = F^H, P1 = F^V, P0 = F^V^H.
- The H bit is 1 in EAV and 0 in SAV.

**Other blanking** (h or v set, t clear): Y = 64, C = 512.

**Active video**
- Chroma multiplexing: even `h_cnt` carries Cb, odd `h_cnt` carries Cr.
- Bars: 8 bars of `H_ACTIVE`/8 pixels each, in order white, yellow, cyan, green, magenta, red, blue, black, using 75 % BT.709 values.
  - Bar index comes from a bar-width down-counter plus a 3-bit index counter. No divider.
- Ramp: Y = 64 + `h_cnt[10:2]`, C = 512.
- Flat colour: Y, plus Cb or Cr by the same even/odd rule, taken from the latched colour.

**Frame-boundary latching**
- `pattern_sel_i` and `colour_i` are latched only at `h_cnt == H_ACTIVE` while `v_cnt == V_TOTAL`-1, i.e. the EAV before frame start.
- Mid-frame changes have no effect until the next frame.

## Timing

- Every output is registered, with latency of one enabled cycle from the counter state.
- Reset values: `fvht_o` = 0, `vdat_bars_o` = 0, `vdat_colour_o` = 0, latched `pattern_sel` = 0, latched colour = `{64, 512, 512}`.
- First enabled cycle after reset: `fvht_o` = `4'b0011`, both video outputs = `{3FF, 3FF}`.
- `cen_i` = 0: all counters, latches and outputs hold.
- Reset asserted mid-line: outputs clear immediately. The next frame starts cleanly after release.
- Simultaneous `h_cnt` and `v_cnt` wrap: `v_cnt` becomes 0, so `v` rises together with the `h` rise at line-0 EAV.

## Structure

- Package `video_pkg` contains:
  - the bar table, an 8-entry array of `{Y, Cb, Cr}`: 721/512/512, 674/176/543, 581/589/176, 534/253/207, 251/771/817, 204/435/848, 111/848/481, 64/512/512;
  - blanking constants 64/512;
  - TRS constants `3FF`/`000`;
  - a function computing `XYZ` from F, V, H;
  - the `fvht` bit-index constants.
- One sub-module, `raster_counter`, holds the `h_cnt`/`v_cnt` counters, wrap logic and flag decode. Pattern muxing stays in the top level.

## Test plan

1. Reset and release, `cen_i` = 1 → `fvht_o` = 0 during reset; first cycle after release `fvht_o` = `4'b0011` and video = `{3FF, 3FF}`.
2. Run one frame → `h` low exactly 1920 of every 2200 enabled cycles; `v` high for 45 lines of 1125; every `v` rise lands on an `h` rise.
3. Capture XYZ words → line 0 EAV = `2D8`, line 0 SAV = `2AC`, active-line EAV = `274`, active-line SAV = `200`; `t` high for exactly 8 cycles per line.
4. Bars, line 45 → pixel 0 = `{721, 512}`, pixel 240 = `{674, 176}`, pixel 241 = `{674, 543}`, pixel 1919 = `{64, 512}`.
5. Set `colour_i` = `{300, 100, 900}` and `pattern_sel_i` = 1 mid-frame → current frame is unchanged; next frame flat output alternates `{300, 100}` / `{300, 900}` and ramp pixel 400 has Y = 164.
6. Toggle `cen_i` with a 50 % random pattern → outputs hold on disabled cycles; the sequence compressed to enabled cycles is identical to test 2.
